// File: rtl/fpu_sched_pkg.sv
// Shared encodings for the FPU operation scheduler: op codes, precision codes and FSM states.
package fpu_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic PREC_SP = 1'b0;
  localparam logic PREC_DP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } stateT;

  function automatic int maxInt(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the requester that was not served last has priority on a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [0:0] last,
  output logic [1:0] gnt,
  output logic [0:0] gnt_idx
);

  logic [0:0] pref;
  assign pref = ~last;

  always_comb begin
    gnt     = 2'b00;
    gnt_idx = pref;
    if (req[pref]) begin
      gnt_idx = pref;
    end else if (req[last]) begin
      gnt_idx = last;
    end
    if (req != 2'b00) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/fpu_op_scheduler.sv
// Shares one FPU between two requesters: accept, launch, wait for done / fixed MUL latency,
// capture and respond; unsupported ops and hung units come back as error responses.
module fpu_op_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int TIMEOUT = 64,
  parameter int DP_EN   = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [3:0]    req_op,
  input  logic [1:0]    req_prec,
  input  logic [127:0]  req_a,
  input  logic [127:0]  req_b,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [63:0]   rsp_result,
  output logic          rsp_cout,
  output logic          rsp_err,
  output logic [63:0]   fpu_a,
  output logic [63:0]   fpu_b,
  output logic [1:0]    fpu_op,
  output logic          fpu_type,
  output logic          fpu_en,
  output logic          fpu_load,
  input  logic [63:0]   fpu_result,
  input  logic          fpu_done,
  input  logic          fpu_cout,
  output logic [1:0]    dbgState
);

  localparam int CNT_W = $clog2(maxInt(TIMEOUT, MUL_LAT));
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  // Handshakes: a request transfers on the edge where req_valid[i] & req_ready[i];
  // a response transfers on the edge where rsp_valid[owner] & rsp_ready[owner].

  stateT            state, nextState;
  logic [0:0]       last, owner, gntIdx;
  logic [1:0]       gnt;
  logic [CNT_W-1:0] cnt;

  logic        accept, badReq, capture, timeout, rspDone;
  logic [1:0]  selOp;
  logic        selPrec;
  logic [63:0] selA, selB;
  logic        opIsMul;

  rr_arb2 u_arb (
    .req     (req_valid),
    .last    (last),
    .gnt     (gnt),
    .gnt_idx (gntIdx)
  );

  assign selOp   = gntIdx[0] ? req_op[3:2]    : req_op[1:0];
  assign selPrec = gntIdx[0] ? req_prec[1]    : req_prec[0];
  assign selA    = gntIdx[0] ? req_a[127:64]  : req_a[63:0];
  assign selB    = gntIdx[0] ? req_b[127:64]  : req_b[63:0];
  assign opIsMul = (fpu_op == OP_MUL);
  assign dbgState = state;

  always_comb begin
    nextState = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    fpu_en    = 1'b0;
    fpu_load  = 1'b0;
    accept    = 1'b0;
    badReq    = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    rspDone   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = gnt;
        if (req_valid != 2'b00) begin
          accept    = 1'b1;
          badReq    = (selOp == OP_DIV) || ((selPrec == PREC_DP) && (DP_EN == 0));
          nextState = badReq ? ST_RESP : ST_LOAD;
        end
      end
      ST_LOAD: begin
        fpu_en    = 1'b1;
        fpu_load  = 1'b1;
        nextState = ST_RUN;
      end
      ST_RUN: begin
        fpu_en = 1'b1;
        // The multiplier has no done flag, so its completion is purely the latency count.
        if (opIsMul) begin
          capture = (cnt == MUL_LAST);
        end else begin
          capture = fpu_done;
        end
        timeout = !capture && (cnt == TO_LAST);
        if (capture || timeout) begin
          nextState = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) begin
          rspDone   = 1'b1;
          nextState = ST_IDLE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last       <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_op     <= 2'b00;
      fpu_type   <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        owner    <= gntIdx;
        fpu_op   <= selOp;
        fpu_type <= selPrec;
        fpu_a    <= (selPrec == PREC_DP) ? selA : {32'b0, selA[31:0]};
        fpu_b    <= (selPrec == PREC_DP) ? selB : {32'b0, selB[31:0]};
        if (badReq) begin
          rsp_result <= '0;
          rsp_cout   <= 1'b0;
          rsp_err    <= 1'b1;
        end
      end
      if (state == ST_LOAD) begin
        cnt <= '0;
      end else if (state == ST_RUN) begin
        cnt <= cnt + 1'b1;
      end
      if (capture) begin
        rsp_result <= (fpu_type == PREC_DP) ? fpu_result : {32'b0, fpu_result[31:0]};
        rsp_cout   <= opIsMul ? 1'b0 : fpu_cout;
        rsp_err    <= 1'b0;
      end else if (timeout) begin
        rsp_result <= '0;
        rsp_cout   <= 1'b0;
        rsp_err    <= 1'b1;
      end
      if (rspDone) begin
        last <= owner;
      end
    end
  end

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Directed bench for fpu_op_scheduler with a small FPU stand-in that raises fpu_done a set
// number of cycles after each launch pulse (or never, when hung).
module tb_fpu_op_scheduler;
  import fpu_sched_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid, req_ready, req_prec, rsp_valid, rsp_ready;
  logic [3:0]    req_op;
  logic [127:0]  req_a, req_b;
  logic [63:0]   rsp_result, fpu_a, fpu_b, fpu_result;
  logic          rsp_cout, rsp_err, fpu_type, fpu_en, fpu_load, fpu_done, fpu_cout;
  logic [1:0]    fpu_op, dbgState;

  int vecs = 0;
  int errs = 0;
  logic [63:0] expQ[$];

  fpu_op_scheduler #(.MUL_LAT(4), .TIMEOUT(64), .DP_EN(0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_prec(req_prec),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_type(fpu_type),
    .fpu_en(fpu_en), .fpu_load(fpu_load),
    .fpu_result(fpu_result), .fpu_done(fpu_done), .fpu_cout(fpu_cout),
    .dbgState(dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  // FPU stand-in: done goes high doneDelay cycles after the launch cycle
  int   doneDelay = 3;
  logic hang = 1'b0;
  logic busy;
  int   dcnt;
  int   loadCount = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      dcnt     <= 0;
      fpu_done <= 1'b0;
    end else begin
      fpu_done <= 1'b0;
      if (fpu_load) begin
        busy <= 1'b1;
        dcnt <= 1;
      end else if (busy) begin
        if (!hang && dcnt == doneDelay - 1) begin
          fpu_done <= 1'b1;
          busy     <= 1'b0;
        end
        dcnt <= dcnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && fpu_load) loadCount <= loadCount + 1;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int idx, input logic [1:0] op, input logic prec,
                        input logic [63:0] a, input logic [63:0] b);
    req_op[idx*2 +: 2]  = op;
    req_prec[idx]       = prec;
    req_a[idx*64 +: 64] = a;
    req_b[idx*64 +: 64] = b;
    req_valid[idx]      = 1'b1;
  endtask

  // Called one cycle after the accept edge; n is the cycle offset from accept.
  task automatic waitRsp(input int idx, input int budget, output int n);
    n = 1;
    while (!rsp_valid[idx] && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic takeRsp(input int idx);
    rsp_ready[idx] = 1'b1;
    tick();
    rsp_ready[idx] = 1'b0;
  endtask

  int n;
  int l0;
  logic sawRsp;

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_op     = '0;
    req_prec   = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = '0;
    fpu_result = '0;
    fpu_cout   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_fpu_en", fpu_en, 1'b0);
    chk("rst_state", dbgState, ST_IDLE);
    reset = 1'b0;
    tick();

    // SP add on r0 while r1 also requests: r0 wins the first tie
    setReq(0, OP_ADD, PREC_SP, 64'h3F800000, 64'h40000000);
    setReq(1, OP_MUL, PREC_SP, 64'h40000000, 64'h40400000);
    fpu_result = 64'h40400000;
    fpu_cout   = 1'b0;
    doneDelay  = 3;
    hang       = 1'b0;
    l0 = loadCount;
    #1;
    chk("tie_first_ready", req_ready, 2'b01);
    expQ.push_back(64'h40400000);
    tick();
    req_valid[0] = 1'b0;
    chk("add_load_pulse", fpu_load, 1'b1);
    chk("add_fpu_a", fpu_a, 64'h3F800000);
    chk("add_fpu_b", fpu_b, 64'h40000000);
    chk("busy_req_ready", req_ready, 2'b00);
    waitRsp(0, 20, n);
    chk("add_latency", n, 5);
    chk("add_rsp_valid", rsp_valid, 2'b01);
    chk("add_result", rsp_result, expQ.pop_front());
    chk("add_err", rsp_err, 1'b0);
    chk("add_load_count", loadCount - l0, 1);
    takeRsp(0);

    // both valid again: r1 now wins; mul result after fixed latency, cout forced 0
    setReq(0, OP_ADD, PREC_SP, 64'h1, 64'h2);
    fpu_result = 64'h40C00000;
    fpu_cout   = 1'b1;
    hang       = 1'b1;
    #1;
    chk("tie_second_ready", req_ready, 2'b10);
    expQ.push_back(64'h40C00000);
    tick();
    req_valid = 2'b00;
    waitRsp(1, 20, n);
    chk("mul_latency", n, 6);
    chk("mul_rsp_valid", rsp_valid, 2'b10);
    chk("mul_result", rsp_result, expQ.pop_front());
    chk("mul_cout", rsp_cout, 1'b0);
    chk("mul_err", rsp_err, 1'b0);
    takeRsp(1);

    // unsupported op and DP with DP disabled: immediate error, no launch
    l0 = loadCount;
    setReq(0, OP_DIV, PREC_SP, 64'h5, 64'h6);
    tick();
    req_valid = 2'b00;
    waitRsp(0, 10, n);
    chk("div_latency", n, 1);
    chk("div_err", rsp_err, 1'b1);
    chk("div_result", rsp_result, 64'h0);
    takeRsp(0);
    setReq(1, OP_ADD, PREC_DP, 64'h3FF0000000000000, 64'h4000000000000000);
    tick();
    req_valid = 2'b00;
    waitRsp(1, 10, n);
    chk("dp_latency", n, 1);
    chk("dp_rsp_valid", rsp_valid, 2'b10);
    chk("dp_err", rsp_err, 1'b1);
    chk("dp_result", rsp_result, 64'h0);
    takeRsp(1);
    chk("err_no_load", loadCount - l0, 0);

    // hung add: timeout error after 64 RUN cycles
    hang       = 1'b1;
    fpu_result = 64'hDEAD;
    setReq(0, OP_ADD, PREC_SP, 64'h7, 64'h8);
    tick();
    req_valid = 2'b00;
    waitRsp(0, 100, n);
    chk("to_latency", n, 66);
    chk("to_err", rsp_err, 1'b1);
    chk("to_result", rsp_result, 64'h0);
    chk("to_cout", rsp_cout, 1'b0);
    takeRsp(0);

    // next request proceeds normally; SP result upper half is zeroed
    hang       = 1'b0;
    doneDelay  = 2;
    fpu_result = 64'hFFFFFFFF12345678;
    fpu_cout   = 1'b1;
    expQ.push_back(64'h0000000012345678);
    setReq(1, OP_SUB, PREC_SP, 64'h9, 64'hA);
    tick();
    req_valid = 2'b00;
    waitRsp(1, 20, n);
    chk("sub_latency", n, 4);
    chk("sub_result", rsp_result, expQ[0]);
    chk("sub_cout", rsp_cout, 1'b1);

    // stalled response: held stable, nothing accepted, non-owner ready ignored
    hang = 1'b1;
    setReq(0, OP_ADD, PREC_SP, 64'h11, 64'h22);
    rsp_ready[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_rsp_valid", rsp_valid, 2'b10);
      chk("stall_result", rsp_result, expQ[0]);
      chk("stall_req_ready", req_ready, 2'b00);
    end
    void'(expQ.pop_front());
    rsp_ready[0] = 1'b0;
    takeRsp(1);

    // r0 accepted, then reset mid-RUN aborts everything
    chk("post_stall_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    chk("pre_reset_state", dbgState, ST_RUN);
    reset = 1'b1;
    #1;
    chk("mid_rst_state", dbgState, ST_IDLE);
    chk("mid_rst_fpu_en", fpu_en, 1'b0);
    chk("mid_rst_fpu_a", fpu_a, 64'h0);
    chk("mid_rst_rsp_valid", rsp_valid, 2'b00);
    chk("mid_rst_rsp_result", rsp_result, 64'h0);
    tick();
    reset = 1'b0;
    sawRsp = 1'b0;
    repeat (10) begin
      tick();
      if (rsp_valid != 2'b00) sawRsp = 1'b1;
    end
    chk("no_rsp_after_reset", sawRsp, 1'b0);
    setReq(0, OP_ADD, PREC_SP, 64'h1, 64'h1);
    setReq(1, OP_ADD, PREC_SP, 64'h1, 64'h1);
    #1;
    chk("rst_ptr_tie", req_ready, 2'b01);
    req_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
